// File: rtl/icache_refill_ctrl_if.sv
// Miss, refill-request, response-beat and block-write signals of the I-cache refill controller.
// The slave modport is the controller side; the master modport is the fetch/memory side.
interface icache_refill_ctrl_if #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64
);
  logic                   miss_i;
  logic [SIZE_PC-1:0]     missAddr_i;
  logic                   flush_i;
  logic                   memReqValid_o;
  logic [SIZE_PC-1:0]     memReqAddr_o;
  logic                   memReqReady_i;
  logic                   memRespValid_i;
  logic [MEM_WIDTH-1:0]   memRespData_i;
  logic                   wrEnable_o;
  logic [SIZE_PC-1:0]     wrAddr_o;
  logic [CACHE_WIDTH-1:0] instBlock_o;
  logic                   busy_o;
  logic [15:0]            refillCount_o;

  modport slave (
    input  miss_i, missAddr_i, flush_i, memReqReady_i, memRespValid_i, memRespData_i,
    output memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o, refillCount_o
  );

  modport master (
    output miss_i, missAddr_i, flush_i, memReqReady_i, memRespValid_i, memRespData_i,
    input  memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o, refillCount_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache refill: one block request, BEATS response beats assembled, one-cycle block write.
// Miss to write strobe is 2 + BEATS cycles minimum; request held until ready, beats may have gaps.
module icache_refill_ctrl #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64
) (
  input logic               clk,
  input logic               reset,
  icache_refill_ctrl_if.slave bus
);

  localparam int BEATS = CACHE_WIDTH / MEM_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS  = $clog2(CACHE_WIDTH / 8);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SIZE_PC-1:0]     addr_q, addr_d;
  logic [CACHE_WIDTH-1:0] block_q, block_d;
  logic [15:0]            refill_cnt_q, refill_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      block_q      <= '0;
      refill_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      block_q      <= block_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    block_d      = block_q;
    refill_cnt_d = refill_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_i && !bus.flush_i) begin
          addr_d           = bus.missAddr_i;
          addr_d[OFFS-1:0] = '0;
          state_d          = REQ;
        end
      end
      REQ: begin
        // An accepted request must still be drained even if flushed in the same cycle.
        if (bus.memReqReady_i) begin
          cnt_d   = '0;
          state_d = bus.flush_i ? DRAIN : RECV;
        end else if (bus.flush_i) begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (bus.memRespValid_i) begin
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
          if (!bus.flush_i) begin
            block_d[int'(cnt_q)*MEM_WIDTH +: MEM_WIDTH] = bus.memRespData_i;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = bus.flush_i ? IDLE : WRITE;
          end else if (bus.flush_i) begin
            state_d = DRAIN;
          end
        end else if (bus.flush_i) begin
          state_d = DRAIN;
        end
      end
      WRITE: begin
        refill_cnt_d = refill_cnt_q + 16'd1;
        state_d      = IDLE;
      end
      DRAIN: begin
        if (bus.memRespValid_i) begin
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.memReqValid_o = (state_q == REQ);
  assign bus.memReqAddr_o  = addr_q;
  assign bus.wrEnable_o    = (state_q == WRITE);
  assign bus.wrAddr_o      = addr_q;
  assign bus.instBlock_o   = block_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.refillCount_o = refill_cnt_q;

endmodule
